// File: rtl/display_scan_if.sv
// Bundle between control logic and the display scanner: segment data in, anode/segment pins out.
// The master drives patterns and masks, the slave (scanner) drives the pins.
interface display_scan_if #(
  parameter int N_DIGITS = 4,
  parameter int SEG_W    = 7
);
  logic [N_DIGITS*SEG_W-1:0] seg_data;
  logic                      load;
  logic [N_DIGITS-1:0]       digit_en;
  logic [N_DIGITS-1:0]       blink_mask;
  logic [N_DIGITS-1:0]       an;
  logic [SEG_W-1:0]          seg;
  logic                      frame_start;

  modport master (
    output seg_data, load, digit_en, blink_mask,
    input  an, seg, frame_start
  );

  modport slave (
    input  seg_data, load, digit_en, blink_mask,
    output an, seg, frame_start
  );
endinterface

// File: rtl/display_scan.sv
// Multiplexed common-anode 7-segment scanner with per-slot dead time, blink and
// frame-synchronous double-buffered segment data. Pin outputs are registered (1 cycle).
module display_scan #(
  parameter int N_DIGITS     = 4,
  parameter int SEG_W        = 7,
  parameter int SLOT_CYC     = 50000,
  parameter int GAP_CYC      = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  display_scan_if.slave  bus
);

  localparam int CW = (SLOT_CYC > 1)     ? $clog2(SLOT_CYC)     : 1;
  localparam int IW = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef logic [N_DIGITS-1:0][SEG_W-1:0] buf_t;

  logic [CW-1:0]       slot_q, slot_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  buf_t                pend_q, pend_d;
  buf_t                act_q, act_d;
  logic                pend_flag_q, pend_flag_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                fs_q, fs_d;

  logic slot_wrap;
  logic frame_bnd;
  logic in_show;
  logic lit;

  always_comb begin
    slot_wrap = (slot_q == CW'(SLOT_CYC - 1));
    frame_bnd = slot_wrap && (idx_q == IW'(N_DIGITS - 1));

    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d  = idx_q;
    if (slot_wrap) begin
      idx_d = frame_bnd ? '0 : idx_q + 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_bnd) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Commit reads the old pending value, so a load on the boundary waits a frame.
    act_d       = act_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (frame_bnd && pend_flag_q) begin
      act_d       = pend_q;
      pend_flag_d = 1'b0;
    end
    if (bus.load) begin
      pend_d      = bus.seg_data;
      pend_flag_d = 1'b1;
    end

    in_show = (GAP_CYC == 0) || (slot_q >= CW'(GAP_CYC));
    lit     = in_show && bus.digit_en[idx_q] &&
              !(bus.blink_mask[idx_q] && blink_ph_q);

    an_d  = '1;
    seg_d = '1;
    if (lit) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_q == IW'(i)) an_d[i] = 1'b0;
      end
      seg_d = act_q[idx_q];
    end

    fs_d = frame_bnd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      pend_q      <= '1;
      act_q       <= '1;
      pend_flag_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= '1;
      fs_q        <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      pend_flag_q <= pend_flag_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed table-driven bench for display_scan: scan order, double buffer, enable, blink, async reset.
module tb_display_scan;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  display_scan_if #(.N_DIGITS(4), .SEG_W(7)) bus ();

  display_scan #(
    .N_DIGITS(4), .SEG_W(7), .SLOT_CYC(8), .GAP_CYC(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic       ld;
    logic [27:0] dat;
    logic [3:0] en;
    logic [3:0] bm;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } vec_t;

  vec_t tbl[$];

  localparam logic [27:0] DAT_D = {7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [27:0] DAT_A = {7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [27:0] DAT_B = {7'h0F, 7'h0E, 7'h0D, 7'h0C};
  localparam logic [27:0] DAT_C = {7'h55, 7'h2A, 7'h33, 7'h4C};

  task automatic add(input int c, input logic ld, input logic [27:0] dat,
                     input logic [3:0] en, input logic [3:0] bm,
                     input logic [3:0] an, input logic [6:0] seg, input logic fs);
    vec_t v;
    v.cyc = c; v.ld = ld; v.dat = dat; v.en = en; v.bm = bm;
    v.an = an; v.seg = seg; v.fs = fs;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic check_pins(input string tag, input int c, input logic [3:0] an,
                            input logic [6:0] seg, input logic fs);
    check({tag, ".an"},  c, 32'(bus.an),          32'(an));
    check({tag, ".seg"}, c, 32'(bus.seg),         32'(seg));
    check({tag, ".fs"},  c, 32'(bus.frame_start), 32'(fs));
  endtask

  // At most one anode low, every cycle
  always @(negedge clk) begin
    n_tests++;
    if ($countones(~bus.an) > 1) begin
      n_fail++;
      $display("FAIL onehot_an: got an=%b expected at most one low bit", bus.an);
    end
  end

  initial begin
    int ti;
    reset_n        = 1'b0;
    bus.load       = 1'b0;
    bus.seg_data   = '1;
    bus.digit_en   = 4'hF;
    bus.blink_mask = 4'h0;

    // scan order and frame pulse, blank active buffer
    add(1,   0, '0, 4'hF, 4'h0, 4'b1111, 7'h7F, 0);
    add(2,   0, '0, 4'hF, 4'h0, 4'b1111, 7'h7F, 0);
    add(3,   0, '0, 4'hF, 4'h0, 4'b1110, 7'h7F, 0);
    add(8,   0, '0, 4'hF, 4'h0, 4'b1110, 7'h7F, 0);
    add(9,   0, '0, 4'hF, 4'h0, 4'b1111, 7'h7F, 0);
    add(11,  0, '0, 4'hF, 4'h0, 4'b1101, 7'h7F, 0);
    add(19,  0, '0, 4'hF, 4'h0, 4'b1011, 7'h7F, 0);
    add(27,  0, '0, 4'hF, 4'h0, 4'b0111, 7'h7F, 0);
    add(31,  0, '0, 4'hF, 4'h0, 4'b0111, 7'h7F, 0);
    add(32,  0, '0, 4'hF, 4'h0, 4'b0111, 7'h7F, 1);
    add(33,  0, '0, 4'hF, 4'h0, 4'b1111, 7'h7F, 0);
    // mid-frame load stays pending until the boundary
    add(40,  1, DAT_D, 4'hF, 4'h0, 4'b1110, 7'h7F, 0);
    add(43,  0, '0, 4'hF, 4'h0, 4'b1101, 7'h7F, 0);
    add(64,  0, '0, 4'hF, 4'h0, 4'b0111, 7'h7F, 1);
    add(67,  0, '0, 4'hF, 4'h0, 4'b1110, 7'h40, 0);
    add(75,  0, '0, 4'hF, 4'h0, 4'b1101, 7'h79, 0);
    add(83,  0, '0, 4'hF, 4'h0, 4'b1011, 7'h24, 0);
    add(91,  0, '0, 4'hF, 4'h0, 4'b0111, 7'h30, 0);
    // two loads in a frame, then a boundary-coincident load
    add(100, 1, DAT_A, 4'hF, 4'h0, 4'b1110, 7'h40, 0);
    add(110, 1, DAT_B, 4'hF, 4'h0, 4'b1101, 7'h79, 0);
    add(123, 0, '0, 4'hF, 4'h0, 4'b0111, 7'h30, 0);
    add(127, 1, DAT_C, 4'hF, 4'h0, 4'b0111, 7'h30, 0);
    add(131, 0, '0, 4'hF, 4'h0, 4'b1110, 7'h0C, 0);
    add(155, 0, '0, 4'hF, 4'h0, 4'b0111, 7'h0F, 0);
    add(160, 0, '0, 4'hF, 4'h0, 4'b0111, 7'h0F, 1);
    add(163, 0, '0, 4'hF, 4'h0, 4'b1110, 7'h4C, 0);
    add(171, 0, '0, 4'hF, 4'h0, 4'b1101, 7'h33, 0);
    // digit 2 disabled: dark slot, frame length unchanged
    add(191, 0, '0, 4'b1011, 4'h0, 4'b0111, 7'h55, 0);
    add(203, 0, '0, 4'b1011, 4'h0, 4'b1101, 7'h33, 0);
    add(209, 0, '0, 4'b1011, 4'h0, 4'b1111, 7'h7F, 0);
    add(211, 0, '0, 4'b1011, 4'h0, 4'b1111, 7'h7F, 0);
    add(216, 0, '0, 4'b1011, 4'h0, 4'b1111, 7'h7F, 0);
    add(219, 0, '0, 4'b1011, 4'h0, 4'b0111, 7'h55, 0);
    // blink digit 0: phase 1 in frames 6,7,10,11, phase 0 in 8,9,12
    add(224, 0, '0, 4'hF, 4'b0001, 4'b0111, 7'h55, 1);
    add(227, 0, '0, 4'hF, 4'b0001, 4'b1111, 7'h7F, 0);
    add(235, 0, '0, 4'hF, 4'b0001, 4'b1101, 7'h33, 0);
    add(259, 0, '0, 4'hF, 4'b0001, 4'b1110, 7'h4C, 0);
    add(291, 0, '0, 4'hF, 4'b0001, 4'b1110, 7'h4C, 0);
    add(323, 0, '0, 4'hF, 4'b0001, 4'b1111, 7'h7F, 0);
    add(331, 0, '0, 4'hF, 4'b0001, 4'b1101, 7'h33, 0);
    add(355, 0, '0, 4'hF, 4'b0001, 4'b1111, 7'h7F, 0);
    add(387, 0, '0, 4'hF, 4'b0001, 4'b1110, 7'h4C, 0);
    add(403, 0, '0, 4'hF, 4'b0001, 4'b1011, 7'h2A, 0);

    repeat (3) @(negedge clk);
    check_pins("reset", 0, 4'b1111, 7'h7F, 1'b0);
    reset_n = 1'b1;

    ti = 0;
    for (int c = 1; c <= 403; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.load = 1'b0;
      if (ti < tbl.size() && tbl[ti].cyc == c) begin
        check_pins("vec", c, tbl[ti].an, tbl[ti].seg, tbl[ti].fs);
        bus.digit_en   = tbl[ti].en;
        bus.blink_mask = tbl[ti].bm;
        if (tbl[ti].ld) begin
          bus.load     = 1'b1;
          bus.seg_data = tbl[ti].dat;
        end
        ti++;
      end
    end

    // async reset in the middle of digit 2's SHOW phase
    reset_n = 1'b0;
    #1;
    check_pins("async_rst", 403, 4'b1111, 7'h7F, 1'b0);
    bus.blink_mask = 4'h0;
    repeat (2) @(negedge clk);
    check_pins("hold_rst", 403, 4'b1111, 7'h7F, 1'b0);
    reset_n = 1'b1;

    for (int c = 1; c <= 33; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1)  check_pins("rst_gap", c, 4'b1111, 7'h7F, 1'b0);
      if (c == 3)  check_pins("rst_d0",  c, 4'b1110, 7'h7F, 1'b0);
      if (c == 11) check_pins("rst_d1",  c, 4'b1101, 7'h7F, 1'b0);
      if (c == 31) check_pins("rst_d3",  c, 4'b0111, 7'h7F, 1'b0);
      if (c == 32) check_pins("rst_fs",  c, 4'b0111, 7'h7F, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Parametrised multiplexed 7-segment display driver for N common-anode digits.
- Generates its own scan timing from the system clock, with inter-digit dead time to suppress ghosting.
- Supports per-digit enable, per-digit blink, and frame-synchronous double-buffered update of segment data.
- Sits between the game/control logic (which supplies segment patterns) and the board's anode/segment pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (>=1)
SEG_W, 7, segment bits per digit
SLOT_CYC, 50000, clock cycles per digit slot (>= GAP_CYC+1)
GAP_CYC, 500, cycles at start of each slot with all anodes off (dead time, >=0)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
seg_data  in  N_DIGITS*SEG_W  segment patterns, active-low; digit i at bits [i*SEG_W +: SEG_W]
load  in  1  one-cycle strobe: capture seg_data into pending buffer
digit_en  in  N_DIGITS  1 = digit displayed, 0 = digit kept dark
blink_mask  in  N_DIGITS  1 = digit blinks
an  out  N_DIGITS  anode select, active-low, one-hot-low or all ones
seg  out  SEG_W  segment drive, active-low
frame_start  out  1  one-cycle pulse when scan returns to digit 0

Behaviour:
- Clock and reset are decided: one clock, clk; asynchronous active-low reset, reset_n.
- Reset (async assert, sync release), all registers:
  - an = all 1, seg = all 1, frame_start = 0.
  - slot counter = 0, digit index = 0, blink counter = 0, blink phase = 0.
  - Pending buffer = all 1, active buffer = all 1, pending flag = 0.
- Slot counter: counts 0..SLOT_CYC-1, then wraps to 0. On wrap, digit index increments; index N_DIGITS-1 wraps to 0.
- Per-slot phases:
  - GAP: counter < GAP_CYC; an all 1, seg all 1.
  - SHOW: counter >= GAP_CYC.
  - With GAP_CYC=0 there is no GAP phase.
- SHOW output for digit i:
  - If digit_en[i]=1 and not (blink_mask[i]=1 and blink phase=1): an has bit i = 0 and all other bits 1; seg = active buffer digit i.
  - Otherwise an = all 1 and seg = all 1. The slot is still consumed, so brightness stays constant regardless of how many digits are enabled.
- an, seg, frame_start are registered: the value in cycle k+1 reflects counter/index state in cycle k, a fixed 1-cycle latency. digit_en and blink_mask are sampled at the same point, with no further latency.
- Frame boundary: the cycle in which index wraps N_DIGITS-1 -> 0 (counter wrap). frame_start is 1 in the cycle after the boundary.
- Double buffer:
  - load=1 copies seg_data into the pending buffer and sets the pending flag.
  - At a frame boundary with the flag set, active <= pending and the flag clears.
  - load on the same cycle as a frame boundary: the commit uses the old pending contents, and the new data is captured and stays pending for the next frame.
  - Multiple loads within one frame: the last one wins.
  - No tearing: the active buffer changes only at frame boundaries.
- Blink: the blink counter increments at each frame boundary. At BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles. Phase 0 = visible.
- N_DIGITS=1: every slot end is a frame boundary.
- Invariant: at most one bit of an is 0 in any cycle.
- Reset mid-slot returns immediately to the reset values.

Test Plan:
Sim params N_DIGITS=4, SLOT_CYC=8, GAP_CYC=2, BLINK_FRAMES=2.
1. Reset, then release with all digit_en=1, no load -> an cycles through 1110, 1101, 1011, 0111 (6 cycles each, 2 cycles 1111 before each) with seg=1111111; frame_start pulses every 32 cycles.
2. load with digits {1000000, 1111001, 0100100, 0110000}, mid-frame -> seg stays 1111111 until the next frame_start, then shows the pattern for the lit digit, e.g. an=1101 -> seg=1111001.
3. Two loads in one frame (A then B), plus a load coincident with a boundary -> only B is shown in the next frame. Boundary-coincident data appears one frame later.
4. digit_en=1011 -> slot of digit 2 shows an=1111 and seg=1111111 for all 8 cycles; frame length is still 32 cycles.
5. blink_mask=0001, all enabled -> digit 0 lit for frames 0-1, dark for frames 2-3, lit again from frame 4; other digits are unaffected.
6. Assert reset_n=0 during SHOW of digit 2 -> an=1111 and seg=1111111 asynchronously. After release, scan restarts at digit 0 with the active buffer blank.
7. Throughout all scenarios, the at-most-one-anode-low invariant is checked every cycle.
